// File: rtl/alarm_controller.sv
// Alarm set-up and firing sequencer for the clock/alarm display path.
// Owns the alarm hour/minute registers, the mode FSM, the blink phase and the ring timer.
module alarm_controller #(
    parameter int unsigned ALARM_H_INIT = 7,
    parameter int unsigned ALARM_M_INIT = 0,
    parameter int unsigned BLINK_TICKS  = 1,
    parameter int unsigned RING_SECS    = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz_i,
    input  logic [6:0] cur_h_i,
    input  logic [6:0] cur_m_i,
    input  logic       mode_btn_i,
    input  logic       inc_btn_i,
    input  logic       en_btn_i,
    input  logic       stop_btn_i,
    output logic [6:0] ih_o,
    output logic [6:0] im_o,
    output logic       isset_o,
    output logic       clockon_o,
    output logic       ahset_o,
    output logic       amset_o,
    output logic       pulse_o,
    output logic       ring_o
);

    localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned RingW  = $clog2(RING_SECS + 1);

    typedef enum logic [1:0] {StShow, StSetH, StSetM, StRing} state_e;

    state_e            state_q, state_d;
    logic [6:0]        ih_q, ih_d;
    logic [6:0]        im_q, im_d;
    logic              isset_q, isset_d;
    logic              pulse_q, pulse_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic [RingW-1:0]  ring_cnt_q, ring_cnt_d;
    logic              match_q, match;
    logic              fire;

    // match_q follows match in every state, so fire is a rising edge of the match window.
    assign match = isset_q && (cur_h_i == ih_q) && (cur_m_i == im_q);
    assign fire  = (state_q == StShow) && match && !match_q;

    always_comb begin
        state_d     = state_q;
        ih_d        = ih_q;
        im_d        = im_q;
        isset_d     = isset_q;
        pulse_d     = pulse_q;
        blink_cnt_d = blink_cnt_q;
        ring_cnt_d  = ring_cnt_q;

        unique case (state_q)
            StShow: begin
                pulse_d = 1'b0;
                if (fire) begin
                    state_d    = StRing;
                    ring_cnt_d = '0;
                end else begin
                    if (mode_btn_i) begin
                        state_d     = StSetH;
                        blink_cnt_d = '0;
                    end
                    if (en_btn_i) begin
                        isset_d = ~isset_q;
                    end
                end
            end
            StSetH, StSetM: begin
                if (mode_btn_i) begin
                    state_d     = (state_q == StSetH) ? StSetM : StShow;
                    pulse_d     = 1'b0;
                    blink_cnt_d = '0;
                end else if (inc_btn_i) begin
                    if (state_q == StSetH) begin
                        ih_d = (ih_q == 7'd23) ? 7'd0 : ih_q + 7'd1;
                    end else begin
                        im_d = (im_q == 7'd59) ? 7'd0 : im_q + 7'd1;
                    end
                    pulse_d     = 1'b0;
                    blink_cnt_d = '0;
                end else if (tick_1hz_i) begin
                    if (blink_cnt_q == BlinkW'(BLINK_TICKS - 1)) begin
                        blink_cnt_d = '0;
                        pulse_d     = ~pulse_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
            StRing: begin
                pulse_d = 1'b0;
                if (en_btn_i) begin
                    state_d = StShow;
                    isset_d = 1'b0;
                end else if (stop_btn_i) begin
                    state_d = StShow;
                end else if (tick_1hz_i) begin
                    ring_cnt_d = ring_cnt_q + 1'b1;
                    if (ring_cnt_q == RingW'(RING_SECS - 1)) begin
                        state_d = StShow;
                    end
                end
            end
            default: state_d = StShow;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StShow;
            ih_q        <= 7'(ALARM_H_INIT);
            im_q        <= 7'(ALARM_M_INIT);
            isset_q     <= 1'b0;
            pulse_q     <= 1'b0;
            blink_cnt_q <= '0;
            ring_cnt_q  <= '0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ih_q        <= ih_d;
            im_q        <= im_d;
            isset_q     <= isset_d;
            pulse_q     <= pulse_d;
            blink_cnt_q <= blink_cnt_d;
            ring_cnt_q  <= ring_cnt_d;
            match_q     <= match;
        end
    end

    assign ih_o      = ih_q;
    assign im_o      = im_q;
    assign isset_o   = isset_q;
    assign clockon_o = (state_q == StShow) || (state_q == StRing);
    assign ahset_o   = (state_q == StSetH);
    assign amset_o   = (state_q == StSetM);
    assign pulse_o   = pulse_q;
    assign ring_o    = (state_q == StRing);

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the alarm rules.
module tb_alarm_controller;

    localparam int unsigned Blink = 2;
    localparam int unsigned RingS = 3;

    logic       clk, rst_n, tick_1hz;
    logic [6:0] cur_h, cur_m;
    logic       mode_btn, inc_btn, en_btn, stop_btn;
    logic [6:0] ih, im;
    logic       isset, clockon, ahset, amset, pulse, ring;

    alarm_controller #(
        .ALARM_H_INIT(7),
        .ALARM_M_INIT(0),
        .BLINK_TICKS (Blink),
        .RING_SECS   (RingS)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz_i(tick_1hz),
        .cur_h_i   (cur_h),
        .cur_m_i   (cur_m),
        .mode_btn_i(mode_btn),
        .inc_btn_i (inc_btn),
        .en_btn_i  (en_btn),
        .stop_btn_i(stop_btn),
        .ih_o      (ih),
        .im_o      (im),
        .isset_o   (isset),
        .clockon_o (clockon),
        .ahset_o   (ahset),
        .amset_o   (amset),
        .pulse_o   (pulse),
        .ring_o    (ring)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: view is "show", "hour", "minute" or "ring".
    string m_view;
    int    m_h, m_m, m_blink_ticks, m_ring_secs;
    bit    m_armed, m_blank, m_prev_match;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_view = "show"; m_h = 7; m_m = 0; m_armed = 0; m_blank = 0;
        m_blink_ticks = 0; m_ring_secs = 0; m_prev_match = 0;
    endtask

    // One clock edge of the alarm rules, evaluated on the inputs sampled at that edge.
    task automatic model_edge();
        bit hit;
        hit = m_armed && (int'(cur_h) == m_h) && (int'(cur_m) == m_m);
        if (m_view == "show") begin
            if (hit && !m_prev_match) begin
                m_view = "ring"; m_ring_secs = 0;
            end else begin
                if (mode_btn) begin m_view = "hour"; m_blank = 0; m_blink_ticks = 0; end
                if (en_btn) m_armed = !m_armed;
            end
        end else if (m_view == "hour" || m_view == "minute") begin
            if (mode_btn) begin
                m_view = (m_view == "hour") ? "minute" : "show";
                m_blank = 0; m_blink_ticks = 0;
            end else if (inc_btn) begin
                if (m_view == "hour") m_h = (m_h + 1) % 24;
                else m_m = (m_m + 1) % 60;
                m_blank = 0; m_blink_ticks = 0;
            end else if (tick_1hz) begin
                m_blink_ticks++;
                if (m_blink_ticks == Blink) begin m_blank = !m_blank; m_blink_ticks = 0; end
            end
        end else begin
            if (en_btn) begin m_view = "show"; m_armed = 0; end
            else if (stop_btn) m_view = "show";
            else if (tick_1hz) begin
                m_ring_secs++;
                if (m_ring_secs == RingS) m_view = "show";
            end
        end
        m_prev_match = hit;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".ih"},      32'(ih),      32'(m_h));
        check({ctx, ".im"},      32'(im),      32'(m_m));
        check({ctx, ".isset"},   32'(isset),   32'(m_armed));
        check({ctx, ".clockon"}, 32'(clockon), 32'(m_view == "show" || m_view == "ring"));
        check({ctx, ".ahset"},   32'(ahset),   32'(m_view == "hour"));
        check({ctx, ".amset"},   32'(amset),   32'(m_view == "minute"));
        check({ctx, ".pulse"},   32'(pulse),   32'(m_blank));
        check({ctx, ".ring"},    32'(ring),    32'(m_view == "ring"));
    endtask

    task automatic step(input bit md, input bit inc, input bit en, input bit stp, input bit tk,
                        input string ctx);
        mode_btn = md; inc_btn = inc; en_btn = en; stop_btn = stp; tick_1hz = tk;
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
        mode_btn = 0; inc_btn = 0; en_btn = 0; stop_btn = 0; tick_1hz = 0;
    endtask

    task automatic incs(input int n, input string ctx);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, ctx);
    endtask

    initial begin
        rst_n = 0; tick_1hz = 0; cur_h = 0; cur_m = 0;
        mode_btn = 0; inc_btn = 0; en_btn = 0; stop_btn = 0;
        model_reset();
        #12;
        check_all("por");
        check("por.ih_const", 32'(ih), 32'd7);
        rst_n = 1;

        // Set sequence: 7:00 -> 10:01
        step(1, 0, 0, 0, 0, "set");
        check("set.ahset", 32'(ahset), 32'd1);
        incs(3, "set");
        step(1, 0, 0, 0, 0, "set");
        check("set.amset", 32'(amset), 32'd1);
        incs(61, "set");
        step(1, 0, 0, 0, 0, "set");
        check("set.ih", 32'(ih), 32'd10);
        check("set.im", 32'(im), 32'd1);
        check("set.clockon", 32'(clockon), 32'd1);

        // Wrap boundaries and mode-beats-inc
        step(1, 0, 0, 0, 0, "wrap");
        incs(13, "wrap");
        check("wrap.ih23", 32'(ih), 32'd23);
        incs(1, "wrap");
        check("wrap.ih0", 32'(ih), 32'd0);
        step(1, 1, 0, 0, 0, "wrap");
        check("wrap.mode_inc_ih", 32'(ih), 32'd0);
        check("wrap.mode_inc_im", 32'(im), 32'd1);
        incs(58, "wrap");
        check("wrap.im59", 32'(im), 32'd59);
        incs(1, "wrap");
        check("wrap.im0", 32'(im), 32'd0);
        step(1, 0, 0, 0, 0, "wrap");

        // Fire at 6:30, stop, no re-fire while still matching
        step(1, 0, 0, 0, 0, "fire");
        incs(6, "fire");
        step(1, 0, 0, 0, 0, "fire");
        incs(30, "fire");
        step(1, 0, 0, 0, 0, "fire");
        cur_h = 6; cur_m = 29;
        step(0, 0, 1, 0, 0, "fire");
        step(0, 0, 0, 0, 0, "fire");
        check("fire.pre", 32'(ring), 32'd0);
        cur_m = 30;
        step(0, 0, 0, 0, 0, "fire");
        check("fire.ring", 32'(ring), 32'd1);
        step(0, 0, 0, 1, 0, "fire");
        check("fire.stop", 32'(ring), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "fire.norefire");
        check("fire.norefire", 32'(ring), 32'd0);

        // Timeout after RingS ticks, then cancel with en
        cur_m = 29; step(0, 0, 0, 0, 0, "tmo");
        cur_m = 30; step(0, 0, 0, 0, 0, "tmo");
        step(0, 0, 0, 0, 1, "tmo");
        step(0, 0, 0, 0, 1, "tmo");
        check("tmo.tick2", 32'(ring), 32'd1);
        step(0, 0, 0, 0, 1, "tmo");
        check("tmo.tick3", 32'(ring), 32'd0);
        cur_m = 29; step(0, 0, 0, 0, 0, "cancel");
        cur_m = 30; step(0, 0, 0, 0, 0, "cancel");
        step(0, 0, 1, 0, 0, "cancel");
        check("cancel.ring", 32'(ring), 32'd0);
        check("cancel.isset", 32'(isset), 32'd0);

        // Blink in SET_H with two ticks per toggle
        step(1, 0, 0, 0, 0, "blink");
        step(0, 0, 0, 0, 1, "blink");
        check("blink.t1", 32'(pulse), 32'd0);
        step(0, 0, 0, 0, 1, "blink");
        check("blink.t2", 32'(pulse), 32'd1);
        step(0, 0, 0, 0, 1, "blink");
        step(0, 0, 0, 0, 1, "blink");
        check("blink.t4", 32'(pulse), 32'd0);
        step(0, 0, 0, 0, 1, "blink");
        step(0, 0, 0, 0, 1, "blink");
        check("blink.t6", 32'(pulse), 32'd1);
        incs(1, "blink");
        check("blink.inc", 32'(pulse), 32'd0);
        incs(23, "blink");
        step(1, 0, 0, 0, 0, "blink");
        step(1, 0, 0, 0, 0, "blink");

        // Arm inside the matching minute: fires next cycle; then async reset mid-ring
        step(0, 0, 1, 0, 0, "arm");
        step(0, 0, 0, 0, 0, "arm");
        check("arm.ring", 32'(ring), 32'd1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("rst");
        check("rst.ring", 32'(ring), 32'd0);
        check("rst.ih_const", 32'(ih), 32'd7);
        @(negedge clk) rst_n = 1;

        // Random phase with current time biased towards the alarm time
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    cur_h = 7'(m_h);
                    cur_m = 7'($urandom_range(0, 1) == 1 ? m_m : (m_m + 59) % 60);
                end else begin
                    cur_h = 7'($urandom_range(0, 23));
                    cur_m = 7'($urandom_range(0, 59));
                end
            end
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
